// File: rtl/instruction_memory_sync.sv
// Writable instruction memory with a load port and a 1-cycle valid/ready fetch port.
// Misaligned or out-of-range addresses are flagged; loads to them are dropped.
module instruction_memory_sync #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_err,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic [1:0]        resp_err,
   input  logic              resp_ready,
   output logic [31:0]       fetch_cnt
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } resp_state_t;

   resp_state_t       r_state;
   resp_state_t       w_state_nxt;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_resp_data;
   logic [1:0]        r_resp_err;
   logic              r_ld_err;
   logic [31:0]       r_fetch_cnt;

   logic [IDX_W-1:0]  w_ld_idx;
   logic              w_ld_mis;
   logic              w_ld_oor;
   logic [IDX_W-1:0]  w_rd_idx;
   logic              w_rd_mis;
   logic              w_rd_oor;
   logic              w_req_ready;
   logic              w_accept;

   // Same decode rule for both ports: word index, alignment, upper-bit range check.
   assign w_ld_idx = ld_addr[IDX_W+1:2];
   assign w_ld_mis = |ld_addr[1:0];
   assign w_ld_oor = |ld_addr[ADDR_W-1:IDX_W+2];
   assign w_rd_idx = req_addr[IDX_W+1:2];
   assign w_rd_mis = |req_addr[1:0];
   assign w_rd_oor = |req_addr[ADDR_W-1:IDX_W+2];

   // Loads win the port, so a fetch never sees a same-cycle write.
   assign w_req_ready = !reset && !ld_en && ((r_state == S_EMPTY) || resp_ready);
   assign w_accept    = req_valid && w_req_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
         S_FULL:  if (resp_ready && !w_accept) w_state_nxt = S_EMPTY;
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_resp_data <= '0;
         r_resp_err  <= '0;
         r_ld_err    <= 1'b0;
         r_fetch_cnt <= '0;
      end else begin
         if (ld_en && !w_ld_mis && !w_ld_oor) begin
            r_mem[w_ld_idx] <= ld_data;
         end
         r_ld_err <= ld_en && (w_ld_mis || w_ld_oor);
         if (w_accept) begin
            r_resp_data <= (w_rd_mis || w_rd_oor) ? '0 : r_mem[w_rd_idx];
            r_resp_err  <= {w_rd_oor, w_rd_mis};
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
      end
   end

   assign req_ready  = w_req_ready;
   assign resp_valid = (r_state == S_FULL);
   assign resp_data  = r_resp_data;
   assign resp_err   = r_resp_err;
   assign ld_err     = r_ld_err;
   assign fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed bench for instruction_memory_sync: loads, fetches, error decode,
// backpressure, load/fetch arbitration and mid-operation reset.
module tb_instruction_memory_sync;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 64;

   logic              clk;
   logic              reset;
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_err;
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic [1:0]        resp_err;
   logic              resp_ready;
   logic [31:0]       fetch_cnt;

   int n_checks;
   int n_errors;
   int exp_cnt;

   instruction_memory_sync #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_err    (ld_err),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .resp_valid(resp_valid),
      .resp_data (resp_data),
      .resp_err  (resp_err),
      .resp_ready(resp_ready),
      .fetch_cnt (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      exp_cnt    = 0;
      reset      = 1'b1;
      ld_en      = 1'b0;
      ld_addr    = '0;
      ld_data    = '0;
      req_valid  = 1'b0;
      req_addr   = '0;
      resp_ready = 1'b1;

      tick();
      tick();
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_err", {30'd0, resp_err}, 32'd0);
      chk("rst_ld_err", {31'd0, ld_err}, 32'd0);
      chk("rst_fetch_cnt", fetch_cnt, 32'd0);
      req_valid = 1'b1;
      settle();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);

      // First fetch after reset reads a cleared word.
      reset    = 1'b0;
      req_addr = 32'h0;
      settle();
      chk("f0_req_ready", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      exp_cnt++;
      chk("f0_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("f0_resp_data", resp_data, 32'd0);
      chk("f0_resp_err", {30'd0, resp_err}, 32'd0);
      chk("f0_fetch_cnt", fetch_cnt, exp_cnt);

      // Three loads.
      ld_en = 1'b1; ld_addr = 32'h0; ld_data = 32'h20000003;
      tick();
      ld_addr = 32'h4; ld_data = 32'h20210004;
      tick();
      ld_addr = 32'h8; ld_data = 32'h00011020;
      tick();
      ld_en = 1'b0;
      chk("ld_ok_no_err", {31'd0, ld_err}, 32'd0);

      // Back-to-back fetches with the consumer always ready.
      req_valid = 1'b1; req_addr = 32'h0;
      settle();
      chk("b2b0_req_ready", {31'd0, req_ready}, 32'd1);
      tick(); exp_cnt++;
      chk("b2b0_data", resp_data, 32'h20000003);
      req_addr = 32'h4;
      settle();
      chk("b2b1_req_ready", {31'd0, req_ready}, 32'd1);
      tick(); exp_cnt++;
      chk("b2b1_data", resp_data, 32'h20210004);
      req_addr = 32'h8;
      settle();
      chk("b2b2_req_ready", {31'd0, req_ready}, 32'd1);
      tick(); exp_cnt++;
      chk("b2b2_data", resp_data, 32'h00011020);
      chk("b2b2_valid", {31'd0, resp_valid}, 32'd1);
      chk("b2b_fetch_cnt", fetch_cnt, exp_cnt);
      req_valid = 1'b0;
      tick();
      chk("drain_valid", {31'd0, resp_valid}, 32'd0);
      chk("drain_data_hold", resp_data, 32'h00011020);

      // Error decode on fetch.
      req_valid = 1'b1; req_addr = 32'h6;
      tick(); exp_cnt++;
      chk("mis_err", {30'd0, resp_err}, 32'd1);
      chk("mis_data", resp_data, 32'd0);
      req_addr = 32'h100;
      tick(); exp_cnt++;
      chk("oor_err", {30'd0, resp_err}, 32'd2);
      chk("oor_data", resp_data, 32'd0);
      req_addr = 32'h102;
      tick(); exp_cnt++;
      chk("both_err", {30'd0, resp_err}, 32'd3);
      req_addr = 32'hFC;
      tick(); exp_cnt++;
      chk("last_word_err", {30'd0, resp_err}, 32'd0);
      chk("last_word_data", resp_data, 32'd0);
      chk("err_fetch_cnt", fetch_cnt, exp_cnt);
      req_valid = 1'b0;

      // Dropped loads pulse ld_err and leave memory untouched.
      ld_en = 1'b1; ld_addr = 32'h102; ld_data = 32'hDEADBEEF;
      tick();
      chk("ld_oor_err", {31'd0, ld_err}, 32'd1);
      ld_addr = 32'h5; ld_data = 32'hCAFEF00D;
      tick();
      chk("ld_mis_err", {31'd0, ld_err}, 32'd1);
      ld_en = 1'b0;
      tick();
      chk("ld_err_clear", {31'd0, ld_err}, 32'd0);
      req_valid = 1'b1; req_addr = 32'h0;
      tick(); exp_cnt++;
      chk("w0_unaffected", resp_data, 32'h20000003);
      req_addr = 32'h4;
      tick(); exp_cnt++;
      chk("w1_unaffected", resp_data, 32'h20210004);

      // Backpressure: response holds, no new accepts.
      resp_ready = 1'b0; req_addr = 32'h8;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
         tick();
         chk("stall_data", resp_data, 32'h20210004);
         chk("stall_valid", {31'd0, resp_valid}, 32'd1);
      end
      chk("stall_fetch_cnt", fetch_cnt, exp_cnt);
      resp_ready = 1'b1;
      settle();
      chk("unstall_req_ready", {31'd0, req_ready}, 32'd1);
      tick(); exp_cnt++;
      chk("unstall_data", resp_data, 32'h00011020);
      chk("unstall_fetch_cnt", fetch_cnt, exp_cnt);

      // Load has priority; the following fetch sees the new word.
      ld_en = 1'b1; ld_addr = 32'hC; ld_data = 32'h8C220000;
      req_addr = 32'hC;
      settle();
      chk("arb_req_ready", {31'd0, req_ready}, 32'd0);
      tick();
      chk("arb_fetch_cnt", fetch_cnt, exp_cnt);
      ld_en = 1'b0;
      settle();
      chk("arb_next_ready", {31'd0, req_ready}, 32'd1);
      tick(); exp_cnt++;
      chk("arb_new_data", resp_data, 32'h8C220000);
      chk("arb_valid", {31'd0, resp_valid}, 32'd1);

      // Reset mid-operation clears response, counter and memory.
      reset = 1'b1;
      settle();
      chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
      tick();
      chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
      chk("midrst_fetch_cnt", fetch_cnt, 32'd0);
      chk("midrst_data", resp_data, 32'd0);
      reset = 1'b0; req_addr = 32'h4;
      tick();
      chk("post_rst_data", resp_data, 32'd0);
      chk("post_rst_valid", {31'd0, resp_valid}, 32'd1);
      chk("post_rst_cnt", fetch_cnt, 32'd1);
      req_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
